// File: rtl/pdp8_pkg.sv
// pdp8_pkg: shared widths, auto-index base, responder state encoding and auto-index qualifier.
package pdp8_pkg;
    localparam int WORD_W = 12;
    localparam int ADDR_W = 12;
    localparam logic [ADDR_W-1:0] AUTOINDEX_BASE = 12'o0010;

    typedef enum logic [1:0] {IDLE, WAIT, WB, ACK} rsp_state_t;

    // Reads with the indirect flag set that target 0010-0017 octal.
    function automatic logic is_autoindex(input logic we, input logic ai, input logic [ADDR_W-1:0] addr);
        return !we && ai && (addr[ADDR_W-1:3] == AUTOINDEX_BASE[ADDR_W-1:3]);
    endfunction
endpackage

// File: rtl/pdp8_mem_array.sv
// pdp8_mem_array: 4096x12 single-port synchronous RAM, write-first, no reset.
module pdp8_mem_array
    import pdp8_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] mem [1 << ADDR_W];

    // Written word appears on rdata at once, so a write or write-back is its own response data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/pdp8_mem_responder.sv
// pdp8_mem_responder: wait-stated PDP-8 memory slave with optional auto-index increment on indirect fetches.
module pdp8_mem_responder
    import pdp8_pkg::*;
#(
    parameter int WAIT_CYCLES  = 2,
    parameter bit AUTOINDEX_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic              ai,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic              ack,
    output logic [WORD_W-1:0] rdata,
    output logic              busy
);
    localparam logic [3:0] WC = 4'(WAIT_CYCLES);

    rsp_state_t        state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] hold;
    logic [WORD_W-1:0] mem_q;
    logic              we_q;
    logic              ai_q;
    logic              auto_in;
    logic              auto_q;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [WORD_W-1:0] ram_wdata;

    assign auto_in = AUTOINDEX_EN && is_autoindex(we, ai, addr);
    assign auto_q  = AUTOINDEX_EN && is_autoindex(we_q, ai_q, addr_q);
    assign rdata   = state == ACK ? mem_q : hold;

    // IDLE addresses the RAM straight from the inputs so a zero-wait request has its word ready in ACK.
    always_comb begin
        ram_addr  = state == IDLE ? addr : addr_q;
        ram_wdata = state == WB ? mem_q + 12'd1 : state == IDLE ? wdata : wdata_q;
        ram_we    = rst && (state == IDLE ? req && we && WC == 4'd0 :
                            state == WAIT ? we_q && cnt == 4'd1 : state == WB);
    end

    pdp8_mem_array u_array (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (mem_q)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            ack     <= 1'b0;
            busy    <= 1'b0;
            cnt     <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            ai_q    <= 1'b0;
            hold    <= '0;
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    addr_q  <= addr;
                    wdata_q <= wdata;
                    we_q    <= we;
                    ai_q    <= ai;
                    cnt     <= WC;
                    busy    <= 1'b1;
                    state   <= WC != 4'd0 ? WAIT : auto_in ? WB : ACK;
                    ack     <= WC == 4'd0 && !auto_in;
                end
                WAIT: if (cnt == 4'd1) begin
                    cnt   <= 4'd0;
                    state <= auto_q ? WB : ACK;
                    ack   <= !auto_q;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                WB: begin
                    state <= ACK;
                    ack   <= 1'b1;
                end
                ACK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    hold  <= mem_q;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pdp8_mem_responder.sv
// tb_pdp8_mem_responder: directed checks of latency, auto-index, hold-off and reset abort on two wait settings.
module tb_pdp8_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req2 = 1'b0;
    logic        req0 = 1'b0;
    logic        we = 1'b0;
    logic        ai = 1'b0;
    logic [11:0] addr = '0;
    logic [11:0] wdata = '0;
    logic        ack2, busy2, ack0, busy0;
    logic [11:0] rdata2, rdata0;
    int          errors = 0;
    int          checks = 0;
    int          n;

    always #5 clk = ~clk;

    pdp8_mem_responder #(.WAIT_CYCLES(2), .AUTOINDEX_EN(1)) dut (
        .clk(clk), .rst(rst), .req(req2), .we(we), .ai(ai), .addr(addr),
        .wdata(wdata), .ack(ack2), .rdata(rdata2), .busy(busy2)
    );

    pdp8_mem_responder #(.WAIT_CYCLES(0), .AUTOINDEX_EN(1)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we), .ai(ai), .addr(addr),
        .wdata(wdata), .ack(ack0), .rdata(rdata0), .busy(busy0)
    );

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %o expected %o", tag, got, exp);
        end
    endtask

    // One request, inputs scrambled after the accept edge; latency counts edges up to the one where ack is sampled.
    task automatic issue(input string tag, input bit fast, input logic w, input logic a,
                         input logic [11:0] ad, input logic [11:0] wd,
                         input int exp_lat, input logic [11:0] exp_rd);
        int lat;
        @(negedge clk);
        we = w; ai = a; addr = ad; wdata = wd;
        if (fast) req0 = 1'b1; else req2 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0; req2 = 1'b0; we = ~w; ai = ~a; addr = ~ad; wdata = ~wd;
        lat = 1;
        while (!(fast ? ack0 : ack2) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 12'(lat), 12'(exp_lat));
        chk({tag, "_rdata"}, fast ? rdata0 : rdata2, exp_rd);
        @(posedge clk); #1;
        chk({tag, "_ackfall"}, 12'(fast ? ack0 : ack2), 12'd0);
        chk({tag, "_hold"}, fast ? rdata0 : rdata2, exp_rd);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", 12'(ack2), 12'd0);
        chk("rst_busy", 12'(busy2), 12'd0);
        chk("rst_rdata", rdata2, 12'o0000);
        chk("rst_ack0", 12'(ack0), 12'd0);
        chk("rst_busy0", 12'(busy0), 12'd0);
        chk("rst_rdata0", rdata0, 12'o0000);
        @(negedge clk) rst = 1'b1;

        issue("wr0200", 0, 1, 0, 12'o0200, 12'o1234, 3, 12'o1234);
        issue("rd0200", 0, 0, 0, 12'o0200, 12'o0000, 3, 12'o1234);
        issue("wr0010", 0, 1, 0, 12'o0010, 12'o7777, 3, 12'o7777);
        issue("ai0010", 0, 0, 1, 12'o0010, 12'o0000, 4, 12'o0000);
        issue("rd0010", 0, 0, 0, 12'o0010, 12'o0000, 3, 12'o0000);
        issue("wr0020", 0, 1, 0, 12'o0020, 12'o0055, 3, 12'o0055);
        issue("ai0020", 0, 0, 1, 12'o0020, 12'o0000, 3, 12'o0055);
        issue("rd0020", 0, 0, 0, 12'o0020, 12'o0000, 3, 12'o0055);
        issue("wr0017", 0, 1, 0, 12'o0017, 12'o0100, 3, 12'o0100);
        issue("ai0017", 0, 0, 1, 12'o0017, 12'o0000, 4, 12'o0101);
        issue("rd0017", 0, 0, 0, 12'o0017, 12'o0000, 3, 12'o0101);

        issue("wr0400", 0, 1, 0, 12'o0400, 12'o0111, 3, 12'o0111);
        issue("wr0500", 0, 1, 0, 12'o0500, 12'o0222, 3, 12'o0222);
        @(negedge clk);
        we = 1'b0; ai = 1'b0; addr = 12'o0400; req2 = 1'b1;
        @(posedge clk); #1;
        addr = 12'o0500;
        n = 1;
        while (!ack2 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("held_lat1", 12'(n), 12'd3);
        chk("held_rdata1", rdata2, 12'o0111);
        @(posedge clk); #1;
        chk("held_ackfall", 12'(ack2), 12'd0);
        chk("held_idle", 12'(busy2), 12'd0);
        @(posedge clk); #1;
        chk("held_accept2", 12'(busy2), 12'd1);
        req2 = 1'b0;
        n = 1;
        while (!ack2 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("held_lat2", 12'(n), 12'd3);
        chk("held_rdata2", rdata2, 12'o0222);
        @(posedge clk); #1;

        issue("wr0300", 0, 1, 0, 12'o0300, 12'o1111, 3, 12'o1111);
        @(negedge clk);
        we = 1'b1; ai = 1'b0; addr = 12'o0300; wdata = 12'o4321; req2 = 1'b1;
        @(posedge clk); #1;
        req2 = 1'b0;
        @(posedge clk); #1;
        chk("abort_inwait", 12'(busy2), 12'd1);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", 12'(busy2), 12'd0);
        chk("abort_ack", 12'(ack2), 12'd0);
        chk("abort_rdata", rdata2, 12'o0000);
        @(negedge clk) rst = 1'b1;
        n = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ack2) n++;
        end
        chk("abort_noack", 12'(n), 12'd0);
        issue("rd0300", 0, 0, 0, 12'o0300, 12'o0000, 3, 12'o1111);

        issue("z_wr0010", 1, 1, 0, 12'o0010, 12'o0005, 1, 12'o0005);
        issue("z_rd0010", 1, 0, 0, 12'o0010, 12'o0000, 1, 12'o0005);
        issue("z_ai0010", 1, 0, 1, 12'o0010, 12'o0000, 2, 12'o0006);
        issue("z_rd0010b", 1, 0, 0, 12'o0010, 12'o0000, 1, 12'o0006);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pdp8_mem_responder.md
PDP8_MEM_RESPONDER -- requirements
Module: pdp8_mem_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, number of wait-state cycles inserted before each response (legal 0..15).
REQ-002 SHALL have parameter AUTOINDEX_EN, default 1, which enables PDP-8 auto-index behaviour on locations 0010-0017 octal.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset; reset is taken on a clk edge while rst=0.
REQ-005 SHALL have port req  input  1  initiator memory request strobe.
REQ-006 SHALL have port we  input  1  request type: 1 = write, 0 = read.
REQ-007 SHALL have port ai  input  1  read is an indirect-address fetch, so auto-index applies when the address qualifies.
REQ-008 SHALL have port addr  input  12  word address, 4096 words.
REQ-009 SHALL have port wdata  input  12  write data.
REQ-010 SHALL have port ack  output  1  one-cycle response pulse.
REQ-011 SHALL have port rdata  output  12  response data; valid when ack=1.
REQ-012 SHALL have port busy  output  1  request in progress; high in every state except IDLE.

Function
REQ-013 SHALL implement a state machine with states IDLE, WAIT, WB and ACK.
REQ-014 In IDLE with req=1, the block SHALL latch addr, we, wdata and ai (accept edge) and go to WAIT, or go directly to the post-wait state when WAIT_CYCLES=0.
REQ-015 WAIT SHALL last exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter loaded on the accept edge.
REQ-016 After WAIT, an auto-index read SHALL go to WB; every other request SHALL go to ACK.
REQ-017 An auto-index read is a read with ai=1, AUTOINDEX_EN=1 and addr[11:3]=9'o001.
REQ-018 In WB the block SHALL compute the stored word +1 modulo 4096 (7777 wraps to 0000) and write it back to the array.
REQ-019 ACK SHALL last one cycle with ack=1, then return to IDLE.
REQ-020 Latency from the accept edge to ack high SHALL be WAIT_CYCLES+1 cycles, or WAIT_CYCLES+2 cycles for an auto-index read.
REQ-021 For a read, rdata in ACK SHALL be the array word; for an auto-index read it SHALL be the incremented value.
REQ-022 For a write, rdata in ACK SHALL equal the latched wdata.
REQ-023 A write SHALL commit to the array on the edge that enters ACK.
REQ-024 rdata SHALL hold its last value outside ACK.
REQ-025 req SHALL be ignored in WAIT, WB and ACK; input changes after the accept edge SHALL have no effect.
REQ-026 The earliest next accept SHALL be the IDLE cycle that follows ACK.
REQ-027 A non-auto-index address with ai=1 SHALL be served as a plain read, with no array modification.

Reset
REQ-028 On reset: state=IDLE, ack=0, busy=0, rdata=0, wait counter=0, latched request cleared.
REQ-029 Array contents SHALL NOT be reset.
REQ-030 Reset during WAIT or WB SHALL abort the request: no ack, and an uncommitted write or auto-index write-back is discarded.
REQ-031 The reset state SHALL become visible in the cycle after the reset edge.

Structure
REQ-032 Shared package pdp8_pkg SHALL hold WORD_W=12, ADDR_W=12, AUTOINDEX_BASE=12'o0010 and the responder state enum.
REQ-033 Storage SHALL be a single sub-module pdp8_mem_array: a 4096x12 single-port synchronous RAM with one read/write port and no reset.

Verification
REQ-034 Write 12'o1234 to 12'o0200, then read 12'o0200 (WAIT_CYCLES=2) -> each ack arrives 3 cycles after accept; read rdata=12'o1234.
REQ-035 Preload 12'o0010=12'o7777, then issue an ai=1 read of 12'o0010 -> ack 4 cycles after accept, rdata=12'o0000; a subsequent plain read returns 12'o0000.
REQ-036 Preload 12'o0020=12'o0055, then issue an ai=1 read of 12'o0020 -> rdata=12'o0055; the location is unchanged.
REQ-037 Hold req=1 continuously, with addr changed mid-request -> only the first address is served; the second accept occurs the cycle after ack falls.
REQ-038 Drive rst=0 for one cycle during WAIT of a write of 12'o4321 to 12'o0300 -> ack never asserts, 12'o0300 keeps its old value, busy=0 after the reset edge.
REQ-039 With WAIT_CYCLES=0, issue a read -> ack 1 cycle after accept; an auto-index read -> ack 2 cycles after accept.
